// File: rtl/decode_pipe_ctrl_pkg.sv
// Shared definitions for the decode-stage pipeline controller:
// register address width, NOP encoding and controller state encodings.
package decode_pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    // NOP is the all-zero instruction word
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        PIPE_RUN   = 2'd0,
        PIPE_STALL = 2'd1,
        PIPE_FLUSH = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/decode_pipe_ctrl_sat_counter.sv
// Saturating up-counter with increment enable; sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/decode_pipe_ctrl.sv
// Pipeline register control around decode: stall freezes fetch and IF/D,
// flush squashes younger work, counters and a watchdog observe the stalls.
module decode_pipe_ctrl
    import decode_pipe_ctrl_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  if_valid,
    input  logic [XLEN-1:0]       if_pc,
    input  logic [XLEN-1:0]       if_instr,
    input  logic                  d_regwrite,
    input  logic [REG_ADDR_W-1:0] d_dest_reg,
    input  logic                  d_memread,
    input  logic                  d_memwrite,
    output logic                  pc_write,
    output logic                  ifd_valid,
    output logic [XLEN-1:0]       ifd_pc,
    output logic [XLEN-1:0]       ifd_instr,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_pc,
    output logic                  ex_regwrite,
    output logic [REG_ADDR_W-1:0] ex_dest_reg,
    output logic                  ex_memread,
    output logic                  ex_memwrite,
    output logic                  m_regwrite,
    output logic [REG_ADDR_W-1:0] m_dest_reg,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count,
    output logic                  stall_err
);

    localparam int RUN_W = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] MAX_RUN = RUN_W'(MAX_STALL);

    pipe_state_t      state, state_next;
    logic [RUN_W-1:0] run_cnt, run_next;
    logic             eff_stall;

    // Flush overrides a stall raised in the same cycle
    assign eff_stall = stall & ~flush;
    assign pc_write  = ~eff_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifd_valid <= 1'b0;
            ifd_pc    <= '0;
            ifd_instr <= XLEN'(NOP_INSTR);
        end else if (flush) begin
            ifd_valid <= 1'b0;
            ifd_instr <= XLEN'(NOP_INSTR);
        end else if (!eff_stall) begin
            ifd_valid <= if_valid;
            ifd_pc    <= if_pc;
            ifd_instr <= if_instr;
        end
    end

    // r0 writes are never flagged so the hazard detector cannot stall on them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_regwrite <= 1'b0;
            ex_dest_reg <= '0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
        end else if (flush || eff_stall) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_dest_reg <= '0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
        end else begin
            ex_valid    <= ifd_valid;
            ex_pc       <= ifd_pc;
            ex_regwrite <= d_regwrite & ifd_valid & (d_dest_reg != '0);
            ex_dest_reg <= d_dest_reg;
            ex_memread  <= d_memread & ifd_valid;
            ex_memwrite <= d_memwrite & ifd_valid;
        end
    end

    // The branch sits in EX during a flush, so EX/M is never squashed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_regwrite <= 1'b0;
            m_dest_reg <= '0;
        end else begin
            m_regwrite <= ex_regwrite;
            m_dest_reg <= ex_dest_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= PIPE_RUN;
            run_cnt   <= '0;
            stall_err <= 1'b0;
        end else begin
            state     <= state_next;
            run_cnt   <= run_next;
            stall_err <= stall_err | (run_next >= MAX_RUN);
        end
    end

    // A stall run continues only while already in STALL; otherwise it restarts
    always_comb begin
        state_next = PIPE_RUN;
        run_next   = '0;
        if (flush)
            state_next = PIPE_FLUSH;
        else if (eff_stall)
            state_next = PIPE_STALL;
        if (eff_stall) begin
            if (state != PIPE_STALL)
                run_next = RUN_W'(1);
            else if (run_cnt == MAX_RUN)
                run_next = run_cnt;
            else
                run_next = run_cnt + RUN_W'(1);
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (eff_stall),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush),
        .count (flush_count)
    );

endmodule

// File: doc/decode_pipe_ctrl.md
Name: decode_pipe_ctrl

Overview:
- Consumer of the decode-stage hazard detector's stall request; owns the IF/D, D/EX and EX/M pipeline registers that carry hazard-relevant state.
- On stall: freezes the PC and IF/D, injects a bubble into D/EX, and keeps feeding the EX and M destination/regwrite fields back to the hazard detector.
- On a taken-branch flush from EX: squashes the younger instructions.
- Keeps stall/flush performance counters and a stall watchdog.

Parameters:
- XLEN, 32, width of PC and instruction.
- CNT_W, 16, width of the saturating performance counters.
- MAX_STALL, 4, consecutive stall cycles that set stall_err (the non-bypassed pipe never needs more than 2).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  stall request from the decode-stage hazard detector.
- flush  in  1  taken-branch redirect from EX; the branch itself is in EX.
- if_valid  in  1  fetch delivers a valid instruction.
- if_pc  in  XLEN  fetch PC.
- if_instr  in  XLEN  fetched instruction.
- d_regwrite  in  1  decoded regwrite of the IF/D instruction.
- d_dest_reg  in  `REG_ADDR  decoded destination register.
- d_memread  in  1  decoded load.
- d_memwrite  in  1  decoded store.
- pc_write  out  1  PC update enable to fetch.
- ifd_valid  out  1  IF/D holds a valid instruction.
- ifd_pc  out  XLEN  IF/D PC.
- ifd_instr  out  XLEN  IF/D instruction, to the decoder.
- ex_valid  out  1  D/EX valid.
- ex_pc  out  XLEN  D/EX PC.
- ex_regwrite  out  1  to the hazard detector.
- ex_dest_reg  out  `REG_ADDR  to the hazard detector.
- ex_memread  out  1  to EX.
- ex_memwrite  out  1  to EX.
- m_regwrite  out  1  to the hazard detector.
- m_dest_reg  out  `REG_ADDR  to the hazard detector.
- stall_cycles  out  CNT_W  saturating count of stall cycles.
- flush_count  out  CNT_W  saturating count of flushes.
- stall_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (async): all registered outputs 0; ifd_instr = 0 (NOP); state RUN; counters 0; stall_err 0.
- Effective stall: eff_stall = stall & ~flush. Flush wins over stall in the same cycle.
- pc_write (combinational): ~eff_stall.
- IF/D register, on each posedge:
  - flush: ifd_valid <= 0, ifd_instr <= 0.
  - else eff_stall: hold all fields.
  - else: load if_valid, if_pc, if_instr.
- D/EX register, on each posedge:
  - flush or eff_stall: bubble. ex_valid, ex_regwrite, ex_memread, ex_memwrite and ex_dest_reg all <= 0; ex_pc holds.
  - else: ex_valid <= ifd_valid; ex_pc <= ifd_pc; ex_memread/ex_memwrite <= d_* & ifd_valid.
  - else, regwrite/dest: ex_regwrite <= d_regwrite & ifd_valid & (d_dest_reg != 0); ex_dest_reg <= d_dest_reg.
  - Writes to r0 are never flagged, so they cause no false stall.
- EX/M register: always advances. m_regwrite <= ex_regwrite; m_dest_reg <= ex_dest_reg. Flush does not squash EX/M, because the branch is in EX.
- Latency: one cycle per stage. A decoded instruction appears on ex_* the cycle after it is in IF/D with eff_stall = 0.
- State machine (observable through the counters):
  - RUN -> STALL on eff_stall.
  - any state -> FLUSH on flush.
  - STALL -> RUN when eff_stall drops.
  - FLUSH lasts one cycle, then goes to RUN, or to STALL if eff_stall.
- Run counter: counts consecutive STALL cycles and clears on leaving STALL. Reaching MAX_STALL sets stall_err, which stays set until reset.
- stall_cycles increments on every eff_stall cycle. flush_count increments on every flush cycle. Both saturate at all-ones with no wrap.
- Reset asserted mid-stall or mid-flush: immediate return to the reset state. pc_write goes to 1 because the combinational path sees eff_stall = 0 once stall is deasserted.

Decomposition:
- `REG_ADDR and the NOP encoding (0) come from the shared define.v.
- Add `PIPE_RUN, `PIPE_STALL and `PIPE_FLUSH state encodings there.
- One natural sub-module: sat_counter (parameterised width, inc enable, async reset), instantiated twice.

Test Plan:
- Reset mid-run -> all outputs 0, pc_write = 1, counters 0.
- Free run: 4 instructions with regwrite, dest 1..4, stall = 0 -> each reaches ex_dest_reg 1 cycle and m_dest_reg 2 cycles after IF/D; pc_write stays 1.
- stall high for 2 cycles with ifd_instr = 0x00221820 -> ifd_* held, pc_write = 0, two bubbles (ex_regwrite = 0, ex_dest_reg = 0), then the instruction issues; stall_cycles = 2.
- stall and flush together -> IF/D squashed (ifd_valid = 0), D/EX bubble, pc_write = 1, EX/M still advances; flush_count = 1, stall_cycles unchanged.
- d_regwrite = 1 with d_dest_reg = 0 -> ex_regwrite = 0.
- stall held 4 cycles (MAX_STALL = 4) -> stall_err = 1, still 1 after stall drops; with CNT_W = 4, 20 stall cycles -> stall_cycles saturates at 15.
